btn_debounce_req: RTL

- Upstream conditioner for the active-low push buttons that feed the counting FSM's go input.
- Synchronises and debounces a raw button, then emits clean level and edge pulses.
- Holds a sticky go request until the consumer acknowledges it, so a consumer running on a slow divided clock cannot miss a press.

---
 rtl/btn_debounce_req_if.sv | 31 +++
 rtl/btn_debounce_req.sv | 126 ++++++++++++
 2 files changed

// File: rtl/btn_debounce_req_if.sv
// Button/consumer signal bundle for btn_debounce_req.
// master = debouncer side, slave = button source plus go_req consumer.
interface btn_debounce_req_if;
  logic btn_n;
  logic go_ack;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic go_req;
  logic long_press;

  modport master (
    input  btn_n,
    input  go_ack,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output go_req,
    output long_press
  );

  modport slave (
    output btn_n,
    output go_ack,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  go_req,
    input  long_press
  );
endinterface

// File: rtl/btn_debounce_req.sv
// Synchronise/debounce an active-low button; registered level, edge pulses and sticky go request.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to build the one-shot long_press detector.
module btn_debounce_req #(
  parameter int unsigned            CNT_WIDTH        = 24,
  parameter logic [CNT_WIDTH-1:0]   DEBOUNCE_COUNT   = CNT_WIDTH'(120000),
  parameter logic [CNT_WIDTH-1:0]   LONG_PRESS_COUNT = CNT_WIDTH'(6000000)
) (
  input logic                 clk,
  input logic                 rst_btn,
  btn_debounce_req_if.master  bus
);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DB_LAST = DEBOUNCE_COUNT - 1'b1;

  if (DEBOUNCE_COUNT < 2 || LONG_PRESS_COUNT == 0) begin : g_bad_param
    $error("btn_debounce_req: DEBOUNCE_COUNT must be >= 2 and LONG_PRESS_COUNT >= 1");
  end

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           sync_q;
  logic                 level_q;
  logic                 press_q;
  logic                 release_q;
  logic                 go_q;
  logic                 btn_s;

  assign btn_s = sync_q[1];

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_WIDTH-1:0] LP_LAST = LONG_PRESS_COUNT - 1'b1;
  logic long_q;
  assign bus.long_press = long_q;
`else
  assign bus.long_press = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      sync_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      go_q      <= 1'b0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      long_q    <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], ~bus.btn_n};
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      long_q    <= 1'b0;
`endif
      // Ack clears first; a qualified press below overrides it in the same cycle.
      if (bus.go_ack) go_q <= 1'b0;

      case (state_q)
        S_RELEASED: begin
          if (btn_s) begin
            state_q <= S_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= S_RELEASED;
          end else if (cnt_q == DB_LAST) begin
            state_q <= S_PRESSED;
            cnt_q   <= '0;
            press_q <= 1'b1;
            go_q    <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!btn_s) begin
            state_q <= S_RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
          else begin
            // Saturation keeps the comparator from matching twice in one hold.
            if (cnt_q == LP_LAST) long_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= S_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= S_RELEASED;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.go_req        = go_q;

endmodule
